// File: rtl/video_pll_reset_sequencer_pkg.sv
// Shared definitions for the VGA PLL reset sequencer: state encodings and default cycle counts.
// The CSR slave imports the same package to decode state_o.
package video_pll_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        StResetPll    = 3'd0,
        StWaitLock    = 3'd1,
        StStableCheck = 3'd2,
        StRun         = 3'd3,
        StFail        = 3'd4
    } pll_seq_state_e;

    localparam int unsigned DEF_RST_PULSE_CYCLES    = 10;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_MAX_RETRIES         = 3;
    localparam int unsigned DEF_CNT_W               = 16;

    localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == LOSS_CNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/video_pll_reset_sequencer_lock_sync.sv
// Two-flop synchronizer bringing the PLL lock indication into the reference clock domain.
module video_pll_reset_sequencer_lock_sync (
    input  logic refclk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/video_pll_reset_sequencer.sv
// Video PLL reset sequencer: pulses PLL reset, waits for lock with timeout/retry, qualifies
// lock stability, then releases the video-domain reset. Lock loss re-runs the sequence.
module video_pll_reset_sequencer
    import video_pll_reset_sequencer_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W               = DEF_CNT_W,
    localparam int unsigned RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               sw_restart,
    output logic               pll_rst,
    output logic               video_rst_n,
    output logic [2:0]         state_o,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               lock_fail,
    output logic [7:0]         lock_loss_cnt
);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    pll_seq_state_e     r_state;
    logic [CNT_W-1:0]   r_timer;
    logic [RETRY_W-1:0] r_retry;
    logic               r_lock_fail;
    logic [7:0]         r_loss_cnt;
    logic               r_pll_rst;
    logic               r_video_rst_n;

    pll_seq_state_e     w_state_d;
    logic [CNT_W-1:0]   w_timer_d;
    logic [RETRY_W-1:0] w_retry_d;
    logic               w_lock_fail_d;
    logic [7:0]         w_loss_cnt_d;
    logic               w_lock_s;

    video_pll_reset_sequencer_lock_sync u_lock_sync (
        .refclk  (refclk),
        .rst_n   (rst_n),
        .i_async (pll_locked),
        .o_sync  (w_lock_s)
    );

    always_comb begin
        w_state_d     = r_state;
        w_retry_d     = r_retry;
        w_lock_fail_d = r_lock_fail;
        w_loss_cnt_d  = r_loss_cnt;

        if (sw_restart) begin
            w_state_d     = StResetPll;
            w_retry_d     = '0;
            w_lock_fail_d = 1'b0;
        end else begin
            unique case (r_state)
                StResetPll: begin
                    if (r_timer == RST_LAST) w_state_d = StWaitLock;
                end
                StWaitLock: begin
                    // Lock takes precedence over a coincident timeout.
                    if (w_lock_s) begin
                        w_state_d = StStableCheck;
                    end else if (r_timer == TIMEOUT_LAST) begin
                        if (r_retry == RETRY_MAX) begin
                            w_state_d     = StFail;
                            w_lock_fail_d = 1'b1;
                        end else begin
                            w_state_d = StResetPll;
                            w_retry_d = r_retry + RETRY_W'(1);
                        end
                    end
                end
                StStableCheck: begin
                    if (!w_lock_s) begin
                        w_state_d = StWaitLock;
                    end else if (r_timer == STABLE_LAST) begin
                        w_state_d = StRun;
                        w_retry_d = '0;
                    end
                end
                StRun: begin
                    if (!w_lock_s) begin
                        w_state_d    = StResetPll;
                        w_loss_cnt_d = sat_inc8(r_loss_cnt);
                    end
                end
                StFail: begin
                    w_state_d = StFail;
                end
                default: begin
                    w_state_d = StResetPll;
                end
            endcase
        end

        w_timer_d = (sw_restart || (w_state_d != r_state)) ? '0 : r_timer + CNT_W'(1);
    end

    // Outputs decode the next state so they line up with the registered state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StResetPll;
            r_timer       <= '0;
            r_retry       <= '0;
            r_lock_fail   <= 1'b0;
            r_loss_cnt    <= '0;
            r_pll_rst     <= 1'b1;
            r_video_rst_n <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_timer       <= w_timer_d;
            r_retry       <= w_retry_d;
            r_lock_fail   <= w_lock_fail_d;
            r_loss_cnt    <= w_loss_cnt_d;
            r_pll_rst     <= (w_state_d == StResetPll) || (w_state_d == StFail);
            r_video_rst_n <= (w_state_d == StRun);
        end
    end

    assign pll_rst       = r_pll_rst;
    assign video_rst_n   = r_video_rst_n;
    assign state_o       = r_state;
    assign retry_cnt     = r_retry;
    assign lock_fail     = r_lock_fail;
    assign lock_loss_cnt = r_loss_cnt;

endmodule
